video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Sink side of the GoWin clock/reset block: consumes clk_pix (60.465 MHz) and generates 1280x720@60Hz CVT-RBv2 raster timing for the HDMI/TMDS encoder path.
- Provides a prefetch request stream running FETCH_LAT cycles ahead of the displayed pixel, so the renderer/framebuffer can return pixel data aligned with de.
- Frame start/stop is gated by a software/boot enable, applied only on frame boundaries.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 8, horizontal front porch (pixels)
- H_SYNC, 32, hsync width (pixels)
- H_BP, 40, horizontal back porch; H_TOTAL = 1360
- V_ACTIVE, 720, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 8, vsync width (lines)
- V_BP, 12, vertical back porch; V_TOTAL = 741
- HS_POL, 1'b1, active level of hsync (RBv2: positive)
- VS_POL, 1'b0, active level of vsync (RBv2: negative)
- FETCH_LAT, 2, cycles req_* leads de/x/y; legal range 1..8

Ports:
- clk_pix  in  1  pixel clock, the only clock
- srst  in  1  synchronous reset, active-high
- en  in  1  run request; sampled as described below
- req_valid  out  1  prefetch: pixel (req_x,req_y) will be displayed FETCH_LAT cycles later
- req_x  out  11  prefetch column 0..1279
- req_y  out  10  prefetch row 0..719
- de  out  1  display enable, aligned with x/y/hsync/vsync
- x  out  11  displayed column, 0 when de=0
- y  out  10  displayed row, 0 when de=0
- hsync  out  1  horizontal sync at HS_POL when asserted
- vsync  out  1  vertical sync at VS_POL when asserted
- frame_start  out  1  one-cycle pulse with the de-aligned pixel (0,0)
- line_start  out  1  one-cycle pulse with every de-aligned x=0 of an active line

Behaviour:
- Reset: state IDLE; hcnt=vcnt=0; all pipeline stages cleared; req_valid=de=frame_start=line_start=0; x=y=req_x=req_y=0; hsync=~HS_POL; vsync=~VS_POL.
- FSM: IDLE, RUN, DRAIN.
- IDLE: counters held at 0, no activity. en=1 -> RUN next cycle, with hcnt=vcnt=0 in the first RUN cycle.
- RUN: hcnt increments 0..H_TOTAL-1, then wraps to 0 and increments vcnt; vcnt wraps at V_TOTAL-1.
  - At the last frame cycle (hcnt=1359, vcnt=740): if en=0 -> DRAIN, else continue. en is ignored at all other times, so frames are never truncated.
- DRAIN: runs FETCH_LAT cycles to flush the delay pipe, then -> IDLE. Outputs reach reset levels when the pipe empties.
- Horizontal order per line: active [0,1279], FP [1280,1287], sync [1288,1319], BP [1320,1359]. Vertical: active [0,719], FP 720, sync [721,728], BP [729,740].
- Stage 0 (registered from counters): req_valid = RUN && hcnt<H_ACTIVE && vcnt<V_ACTIVE; req_x/req_y = hcnt/vcnt when req_valid, else 0.
- Outputs de, x, y, hsync, vsync, frame_start, line_start are stage-0 values delayed by exactly FETCH_LAT further register stages. This gives req_valid at cycle t implying de at t+FETCH_LAT with the same coordinates.
- vsync asserts/deasserts aligned with hcnt=0 of the sync lines.
- srst mid-frame: immediate return to reset values, including the pipe. No partial pulses are emitted afterward.
- srst and en both high: srst wins.
- Widths: counters are 11 bits and 10 bits; compares are unsigned. H_TOTAL and V_TOTAL are derived by the package, never hard-coded.

Decomposition:
- Package video_timing_pkg: CVT-RBv2 720p constants, derived H_TOTAL/V_TOTAL, and x/y typedefs (logic [10:0], logic [9:0]).
- One sub-module: video_delay_pipe, a parameterised N-stage register shift with synchronous clear, used for the FETCH_LAT alignment.

Test Plan:
- Reset release, en=1 at cycle 0: req_valid first high in cycle 2 with (0,0); de first high in cycle 4 (FETCH_LAT=2) with frame_start=1, line_start=1.
- One full line: de high for exactly 1280 cycles; hsync at HS_POL for 32 cycles starting 1288 cycles after de rises; line period 1360 cycles.
- One full frame: 720 line_start pulses; vsync at VS_POL for 8×1360 cycles; frame_start period 1,007,760 cycles; x/y sequence is monotonic with no gaps.
- Deassert en mid-frame at vcnt=300: frame completes to (1279,719); no new frame_start; outputs reach reset levels FETCH_LAT cycles after the frame end. Reassert en: a new frame_start arrives FETCH_LAT+2 cycles later.
- srst pulse at hcnt=500, vcnt=100: next cycle all outputs are at reset levels, and no stale de emerges from the pipe.
- FETCH_LAT=5 build: for every cycle, req_* at t equals de/x/y at t+5 (scoreboard over 2 frames).

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared constants and types for the 1280x720@60 CVT-RBv2 raster generator.
// Line and frame totals are always derived from the four span components.
package video_timing_pkg;

   typedef logic [10:0] x_t;
   typedef logic [9:0]  y_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // One pixel's worth of de-aligned raster signals carried through the delay pipe.
   typedef struct packed {
      logic de;
      x_t   x;
      y_t   y;
      logic hsync;
      logic vsync;
      logic frame_start;
      logic line_start;
   } pix_s;

   localparam int   CVT_H_ACTIVE  = 1280;
   localparam int   CVT_H_FP      = 8;
   localparam int   CVT_H_SYNC    = 32;
   localparam int   CVT_H_BP      = 40;
   localparam int   CVT_V_ACTIVE  = 720;
   localparam int   CVT_V_FP      = 1;
   localparam int   CVT_V_SYNC    = 8;
   localparam int   CVT_V_BP      = 12;
   localparam logic CVT_HS_POL    = 1'b1;
   localparam logic CVT_VS_POL    = 1'b0;
   localparam int   CVT_FETCH_LAT = 2;

   function automatic int span_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/video_delay_pipe.sv
// N-stage register shift with synchronous clear to a configurable idle value;
// aligns the de-side raster signals FETCH_LAT cycles behind the request stage.
module video_delay_pipe #(
   parameter int            N       = 2,
   parameter int            W       = 1,
   parameter logic [W-1:0]  CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          clr,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout
);

   logic [W-1:0] stage_q [N];
   logic [W-1:0] stage_d [N];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < N; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < N; i++) begin
            stage_q[i] <= CLR_VAL;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[N-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: frame-gated counters, a registered prefetch stage,
// and a FETCH_LAT-deep delay pipe producing de-aligned display timing.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = CVT_H_ACTIVE,
   parameter int   H_FP      = CVT_H_FP,
   parameter int   H_SYNC    = CVT_H_SYNC,
   parameter int   H_BP      = CVT_H_BP,
   parameter int   V_ACTIVE  = CVT_V_ACTIVE,
   parameter int   V_FP      = CVT_V_FP,
   parameter int   V_SYNC    = CVT_V_SYNC,
   parameter int   V_BP      = CVT_V_BP,
   parameter logic HS_POL    = CVT_HS_POL,
   parameter logic VS_POL    = CVT_VS_POL,
   parameter int   FETCH_LAT = CVT_FETCH_LAT
) (
   input  logic        clk_pix,
   input  logic        srst,
   input  logic        en,
   output logic        req_valid,
   output logic [10:0] req_x,
   output logic [9:0]  req_y,
   output logic        de,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic        line_start
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam pix_s IDLE_PIX = '{de: 1'b0, x: 11'd0, y: 10'd0, hsync: ~HS_POL,
                                 vsync: ~VS_POL, frame_start: 1'b0, line_start: 1'b0};

   state_e     state_q, state_d;
   x_t         hcnt_q, hcnt_d;
   y_t         vcnt_q, vcnt_d;
   logic [3:0] drain_q, drain_d;
   pix_s       s0_q, s0_d;
   pix_s       pipe_out;
   logic       run_s, act_s, line_end_s, frame_end_s, hs_win_s, vs_win_s;

   assign run_s       = (state_q == ST_RUN);
   assign line_end_s  = (hcnt_q == x_t'(H_TOTAL - 1));
   assign frame_end_s = line_end_s && (vcnt_q == y_t'(V_TOTAL - 1));
   assign act_s       = run_s && (hcnt_q < x_t'(H_ACTIVE)) && (vcnt_q < y_t'(V_ACTIVE));
   assign hs_win_s    = (hcnt_q >= x_t'(H_ACTIVE + H_FP)) && (hcnt_q < x_t'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_win_s    = (vcnt_q >= y_t'(V_ACTIVE + V_FP)) && (vcnt_q < y_t'(V_ACTIVE + V_FP + V_SYNC));

   // en only matters in IDLE and on the last cycle of a frame, so frames are never cut short.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            hcnt_d  = 11'd0;
            vcnt_d  = 10'd0;
            drain_d = 4'd0;
            state_d = en ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            if (line_end_s) begin
               hcnt_d = 11'd0;
               vcnt_d = frame_end_s ? 10'd0 : vcnt_q + 10'd1;
            end else begin
               hcnt_d = hcnt_q + 11'd1;
            end
            state_d = (frame_end_s && !en) ? ST_DRAIN : ST_RUN;
         end
         ST_DRAIN: begin
            hcnt_d = 11'd0;
            vcnt_d = 10'd0;
            if (drain_q == 4'(FETCH_LAT - 1)) begin
               state_d = ST_IDLE;
               drain_d = 4'd0;
            end else begin
               state_d = ST_DRAIN;
               drain_d = drain_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hcnt_d  = 11'd0;
            vcnt_d  = 10'd0;
            drain_d = 4'd0;
         end
      endcase
   end

   // Stage 0: request coordinates plus the raster flags that travel down the pipe.
   always_comb begin
      s0_d             = IDLE_PIX;
      s0_d.de          = act_s;
      s0_d.x           = act_s ? hcnt_q : 11'd0;
      s0_d.y           = act_s ? vcnt_q : 10'd0;
      s0_d.hsync       = (run_s && hs_win_s) ? HS_POL : ~HS_POL;
      s0_d.vsync       = (run_s && vs_win_s) ? VS_POL : ~VS_POL;
      s0_d.frame_start = act_s && (hcnt_q == 11'd0) && (vcnt_q == 10'd0);
      s0_d.line_start  = act_s && (hcnt_q == 11'd0);
   end

   // FSM, counters and the request stage.
   always_ff @(posedge clk_pix) begin
      if (srst) begin
         state_q <= ST_IDLE;
         hcnt_q  <= 11'd0;
         vcnt_q  <= 10'd0;
         drain_q <= 4'd0;
         s0_q    <= IDLE_PIX;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         drain_q <= drain_d;
         s0_q    <= s0_d;
      end
   end

   video_delay_pipe #(
      .N       (FETCH_LAT),
      .W       ($bits(pix_s)),
      .CLR_VAL (IDLE_PIX)
   ) u_pipe (
      .clk  (clk_pix),
      .clr  (srst),
      .din  (s0_q),
      .dout (pipe_out)
   );

   assign req_valid   = s0_q.de;
   assign req_x       = s0_q.x;
   assign req_y       = s0_q.y;
   assign de          = pipe_out.de;
   assign x           = pipe_out.x;
   assign y           = pipe_out.y;
   assign hsync       = pipe_out.hsync;
   assign vsync       = pipe_out.vsync;
   assign frame_start = pipe_out.frame_start;
   assign line_start  = pipe_out.line_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two reduced rasters (FETCH_LAT 2 and 5) and the
// full 720p default build, all checked every cycle against a raster-position model.
module tb_video_timing_gen;

   localparam int NI = 3;

   int cfg_ha  [NI] = '{16, 16, 1280};
   int cfg_hfp [NI] = '{2, 2, 8};
   int cfg_hs  [NI] = '{3, 3, 32};
   int cfg_hbp [NI] = '{4, 4, 40};
   int cfg_va  [NI] = '{6, 6, 720};
   int cfg_vfp [NI] = '{1, 1, 1};
   int cfg_vs  [NI] = '{2, 2, 8};
   int cfg_vbp [NI] = '{2, 2, 12};
   int cfg_fl  [NI] = '{2, 5, 2};

   logic clk_pix = 1'b0;
   logic srst;
   logic en;

   logic [NI-1:0] rv_w, de_w, hs_w, vs_w, fs_w, ls_w;
   logic [10:0]   rx_w [NI];
   logic [9:0]    ry_w [NI];
   logic [10:0]   x_w  [NI];
   logic [9:0]    y_w  [NI];
   logic [47:0]   obs  [NI];

   logic [47:0] idle_vec = {1'b0, 11'd0, 10'd0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};

   // Model: raster position p = v*H_TOTAL + h of the counters, -1 when not running.
   int pos  [NI];
   int cool [NI];
   int hist [NI][9];
   int cyc, n_cmp, n_err;

   always #5 clk_pix = ~clk_pix;

   video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1),
                      .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b0), .FETCH_LAT(2)) dut_s2 (
      .clk_pix(clk_pix), .srst(srst), .en(en), .req_valid(rv_w[0]), .req_x(rx_w[0]), .req_y(ry_w[0]),
      .de(de_w[0]), .x(x_w[0]), .y(y_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]),
      .frame_start(fs_w[0]), .line_start(ls_w[0]));

   video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1),
                      .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b0), .FETCH_LAT(5)) dut_s5 (
      .clk_pix(clk_pix), .srst(srst), .en(en), .req_valid(rv_w[1]), .req_x(rx_w[1]), .req_y(ry_w[1]),
      .de(de_w[1]), .x(x_w[1]), .y(y_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]),
      .frame_start(fs_w[1]), .line_start(ls_w[1]));

   video_timing_gen dut_full (
      .clk_pix(clk_pix), .srst(srst), .en(en), .req_valid(rv_w[2]), .req_x(rx_w[2]), .req_y(ry_w[2]),
      .de(de_w[2]), .x(x_w[2]), .y(y_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]),
      .frame_start(fs_w[2]), .line_start(ls_w[2]));

   for (genvar g = 0; g < NI; g++) begin : g_obs
      assign obs[g] = {rv_w[g], rx_w[g], ry_w[g], de_w[g], x_w[g], y_w[g],
                       hs_w[g], vs_w[g], fs_w[g], ls_w[g]};
   end

   function automatic int ht(input int i);
      return cfg_ha[i] + cfg_hfp[i] + cfg_hs[i] + cfg_hbp[i];
   endfunction

   function automatic int vt(input int i);
      return cfg_va[i] + cfg_vfp[i] + cfg_vs[i] + cfg_vbp[i];
   endfunction

   function automatic logic [21:0] req_part(input int i, input int p);
      int h, v;
      if (p < 0) return 22'd0;
      h = p % ht(i);
      v = p / ht(i);
      if (h < cfg_ha[i] && v < cfg_va[i]) return {1'b1, 11'(h), 10'(v)};
      else return 22'd0;
   endfunction

   function automatic logic [25:0] disp_part(input int i, input int p);
      int h, v;
      logic act, hs, vs;
      if (p < 0) return {1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 2'b00};
      h   = p % ht(i);
      v   = p / ht(i);
      act = (h < cfg_ha[i]) && (v < cfg_va[i]);
      hs  = (h >= cfg_ha[i] + cfg_hfp[i]) && (h < cfg_ha[i] + cfg_hfp[i] + cfg_hs[i]);
      vs  = !((v >= cfg_va[i] + cfg_vfp[i]) && (v < cfg_va[i] + cfg_vfp[i] + cfg_vs[i]));
      return {act, act ? 11'(h) : 11'd0, act ? 10'(v) : 10'd0, hs, vs,
              act && (p == 0), act && (h == 0)};
   endfunction

   task automatic check_int(input string tag, input int got, input int want);
      n_cmp++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic check_vec(input string tag, input int i, input logic [47:0] want);
      n_cmp++;
      assert (obs[i] === want) else begin
         n_err++;
         $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs[i], want);
      end
   endtask

   // One clock: advance the model with the inputs sampled at this edge, then compare.
   task automatic step();
      @(posedge clk_pix);
      for (int i = 0; i < NI; i++) begin
         if (srst) begin
            pos[i]  = -1;
            cool[i] = 0;
            for (int k = 0; k < 9; k++) hist[i][k] = -1;
         end else begin
            for (int k = 8; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = pos[i];
            if (pos[i] < 0) begin
               if (cool[i] > 0) cool[i]--;
               else if (en) pos[i] = 0;
            end else if (pos[i] == ht(i) * vt(i) - 1) begin
               if (en) pos[i] = 0;
               else begin
                  pos[i]  = -1;
                  cool[i] = cfg_fl[i];
               end
            end else begin
               pos[i]++;
            end
         end
      end
      cyc++;
      #1;
      for (int i = 0; i < NI; i++) begin
         check_vec("cycle", i, {req_part(i, hist[i][0]), disp_part(i, hist[i][cfg_fl[i]])});
      end
   endtask

   initial begin
      int first_req0, first_de0, first_de1, rise2, hs2, de_cnt2, ls_cnt0, vs_cnt0;
      int fs_t[$];
      int ls2[$];
      int found, last_x, last_y, fs_cnt, n, stale;

      n_cmp = 0; n_err = 0; cyc = 0;
      for (int i = 0; i < NI; i++) begin
         pos[i] = -1; cool[i] = 0;
         for (int k = 0; k < 9; k++) hist[i][k] = -1;
      end
      srst = 1'b1;
      en   = 1'b0;
      repeat (3) step();
      for (int i = 0; i < NI; i++) check_vec("reset", i, idle_vec);

      // Start-up, first line of 720p, and a few reduced frames.
      srst = 1'b0; en = 1'b1; cyc = 0;
      first_req0 = -1; first_de0 = -1; first_de1 = -1; rise2 = -1; hs2 = -1;
      de_cnt2 = 0; ls_cnt0 = 0; vs_cnt0 = 0;
      for (int k = 0; k < 1400; k++) begin
         step();
         if (first_req0 < 0 && rv_w[0]) first_req0 = cyc;
         if (first_de0 < 0 && de_w[0]) first_de0 = cyc;
         if (first_de1 < 0 && de_w[1]) first_de1 = cyc;
         if (fs_w[0]) fs_t.push_back(cyc);
         if (fs_t.size() == 1) begin
            if (ls_w[0]) ls_cnt0++;
            if (!vs_w[0]) vs_cnt0++;
         end
         if (de_w[2]) begin
            if (rise2 < 0) rise2 = cyc;
            if (cyc < rise2 + 1360) de_cnt2++;
         end
         if (hs_w[2] && hs2 < 0) hs2 = cyc;
         if (ls_w[2]) ls2.push_back(cyc);
      end
      check_int("first_req_cycle", first_req0, 2);
      check_int("first_de_cycle_fl2", first_de0, 4);
      check_int("first_de_cycle_fl5", first_de1, 7);
      check_int("frame_period", (fs_t.size() >= 2) ? fs_t[1] - fs_t[0] : -1, 275);
      check_int("line_starts_per_frame", ls_cnt0, 6);
      check_int("vsync_active_cycles", vs_cnt0, 50);
      check_int("de_cycles_720p_line", de_cnt2, 1280);
      check_int("hsync_offset_720p", (rise2 >= 0 && hs2 >= 0) ? hs2 - rise2 : -1, 1288);
      check_int("line_period_720p", (ls2.size() >= 2) ? ls2[1] - ls2[0] : -1, 1360);

      // Random en toggling; the model decides where it takes effect.
      for (int k = 0; k < 16; k++) begin
         en = 1'($urandom_range(0, 1));
         repeat ($urandom_range(10, 80)) step();
      end

      // Stop mid-frame: the frame must complete, then nothing until en returns.
      en = 1'b1; found = 0;
      for (int k = 0; k < 2000 && found == 0; k++) begin
         step();
         if (de_w[0] && y_w[0] == 10'd3) found = 1;
      end
      check_int("wait_mid_frame", found, 1);
      en = 1'b0; last_x = -1; last_y = -1; fs_cnt = 0;
      for (int k = 0; k < 400; k++) begin
         step();
         if (de_w[0]) begin last_x = int'(x_w[0]); last_y = int'(y_w[0]); end
         if (fs_w[0]) fs_cnt++;
      end
      check_int("stop_last_x", last_x, 15);
      check_int("stop_last_y", last_y, 5);
      check_int("stop_no_frame_start", fs_cnt, 0);
      check_vec("stopped_idle", 0, idle_vec);
      en = 1'b1; n = -1;
      for (int k = 1; k <= 20 && n < 0; k++) begin
         step();
         if (fs_w[0]) n = k;
      end
      check_int("restart_latency", n, 4);

      // Synchronous reset in the middle of an active line.
      found = 0;
      for (int k = 0; k < 600 && found == 0; k++) begin
         step();
         if (de_w[0] && x_w[0] == 11'd8 && y_w[0] == 10'd2) found = 1;
      end
      check_int("wait_srst_point", found, 1);
      srst = 1'b1;
      step();
      for (int i = 0; i < NI; i++) check_vec("srst_clear", i, idle_vec);
      srst = 1'b0; en = 1'b0; stale = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (|de_w || |fs_w || |ls_w || |rv_w) stale++;
      end
      check_int("no_stale_after_srst", stale, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
